// File: rtl/bonsai_run_feeder_if.sv
// Key-stream handshake into the run feeder: the producer drives key/last/valid, the feeder returns ready.
interface bonsai_run_feeder_if #(
  parameter int DATA_W = 32
);
  logic              i_valid;
  logic [DATA_W-1:0] i_data;
  logic              i_last;
  logic              o_ready;

  modport master (output i_valid, i_data, i_last, input o_ready);
  modport slave  (input i_valid, i_data, i_last, output o_ready);
endinterface

// File: rtl/bonsai_run_feeder.sv
// Cuts a nonzero key stream into nondecreasing, zero-terminated runs written alternately to the A/B merge FIFOs.
// Optional per-run length limit of MAX_RUN keys: define BONSAI_RUN_FEEDER_MAXLEN_EN.
module bonsai_run_feeder #(
  parameter int DATA_W  = 32,
  parameter int MAX_RUN = 1024,
  parameter int CNT_W   = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  bonsai_run_feeder_if.slave s_in,
  input  logic               i_fifo_a_full,
  input  logic               i_fifo_b_full,
  output logic               o_wr_a,
  output logic               o_wr_b,
  output logic [DATA_W-1:0]  o_data,
  output logic [CNT_W-1:0]   o_runs,
  output logic               o_done,
  output logic               o_err
);
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_TERM, S_PAD, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic              side_q, side_d;
  logic              pend_q, pend_d;
  logic              eos_q, eos_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  runs_q, runs_d;
  logic              wr_done, free, brk, ready, accept, key_zero, len_hit;

  assign o_wr_a  = pend_q & ~side_q & ~i_fifo_a_full;
  assign o_wr_b  = pend_q &  side_q & ~i_fifo_b_full;
  assign o_data  = data_q;
  assign o_runs  = runs_q;
  assign o_done  = (state_q == S_DONE);
  assign o_err   = err_q;

  assign wr_done  = o_wr_a | o_wr_b;
  assign free     = ~pend_q | wr_done;
  assign key_zero = (s_in.i_data == '0);

`ifdef BONSAI_RUN_FEEDER_MAXLEN_EN
  localparam int LEN_W = $clog2(MAX_RUN + 1);
  logic [LEN_W-1:0] len_q, len_d;
  assign len_hit = (len_q >= LEN_W'(MAX_RUN));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) len_q <= '0;
    else          len_q <= len_d;
  end

  // Counts nonzero keys in the open run; cleared whenever a terminator lands.
  always_comb begin
    len_d = len_q;
    if (state_q == S_TERM && wr_done)
      len_d = '0;
    else if (accept && !key_zero && (state_q == S_IDLE || state_q == S_RUN))
      len_d = (state_q == S_IDLE) ? LEN_W'(1) : len_q + LEN_W'(1);
  end
`else
  assign len_hit = 1'b0;
  // MAX_RUN has no effect while runs are unbounded.
  if (MAX_RUN < 1) begin : g_max_run_ignored
  end
`endif

  // Zero keys never break a run: they are dropped and only flag o_err.
  assign brk    = (state_q == S_RUN) & s_in.i_valid & ~key_zero &
                  ((s_in.i_data < last_q) | len_hit);
  assign ready  = i_rst_n & ((state_q == S_IDLE) | (state_q == S_RUN)) & free & ~brk & ~eos_q;
  assign accept = s_in.i_valid & ready;
  assign s_in.o_ready = ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      last_q  <= '0;
      side_q  <= 1'b0;
      pend_q  <= 1'b0;
      eos_q   <= 1'b0;
      err_q   <= 1'b0;
      runs_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      last_q  <= last_d;
      side_q  <= side_d;
      pend_q  <= pend_d;
      eos_q   <= eos_d;
      err_q   <= err_d;
      runs_q  <= runs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    last_d  = last_q;
    side_d  = side_q;
    pend_d  = pend_q & ~wr_done;
    eos_d   = eos_q;
    err_d   = err_q | (accept & key_zero);
    runs_d  = runs_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!key_zero) begin
            data_d  = s_in.i_data;
            last_d  = s_in.i_data;
            pend_d  = 1'b1;
            eos_d   = s_in.i_last;
            state_d = S_RUN;
          end else if (s_in.i_last) begin
            eos_d = 1'b1;
            // Nothing open to close: only the run-count parity decides whether B needs a pad.
            if (runs_q[0]) begin
              data_d  = '0;
              side_d  = 1'b1;
              pend_d  = 1'b1;
              state_d = S_PAD;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_RUN: begin
        if ((brk | eos_q) & free) begin
          data_d  = '0;
          pend_d  = 1'b1;
          state_d = S_TERM;
        end else if (accept) begin
          eos_d = s_in.i_last;
          if (!key_zero) begin
            data_d = s_in.i_data;
            last_d = s_in.i_data;
            pend_d = 1'b1;
          end
        end
      end
      S_TERM: begin
        if (wr_done) begin
          side_d = ~side_q;
          runs_d = runs_q + CNT_W'(1);
          if (!eos_q) begin
            state_d = S_IDLE;
          end else if (!runs_q[0]) begin
            data_d  = '0;
            side_d  = 1'b1;
            pend_d  = 1'b1;
            state_d = S_PAD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_PAD: begin
        if (wr_done) begin
          runs_d  = runs_q + CNT_W'(1);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule
